// File: rtl/ram_lut_pkg.sv
// Shared types and helpers for the dual-port LUT RAM slice.
// Clear-sequencer state and address-width derivation.
package ram_lut_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } ram_clr_state_t;

  function automatic int ram_clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/ram_dp_lut_clr_if.sv
// Bus bundle for ram_dp_lut_clr: write/read ports plus clear control.
// master drives requests, slave is the RAM.
interface ram_dp_lut_clr_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 6
);
  logic             WE;
  logic [AW-1:0]    A;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] WMASK;
  logic [AW-1:0]    DPRA;
  logic             CLR;
  logic [WIDTH-1:0] SPO;
  logic [WIDTH-1:0] DPO;
  logic             BUSY;
  logic             CLR_DONE;

  modport master (
    output WE, A, D, WMASK, DPRA, CLR,
    input  SPO, DPO, BUSY, CLR_DONE
  );

  modport slave (
    input  WE, A, D, WMASK, DPRA, CLR,
    output SPO, DPO, BUSY, CLR_DONE
  );
endinterface

// File: rtl/ram_lut_core.sv
// WIDTH x DEPTH LUT array: one masked write port, two async reads.
// No reset; callers keep addresses in range.
module ram_lut_core #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] wmask,
  input  logic [AW-1:0]    ra0,
  input  logic [AW-1:0]    ra1,
  output logic [WIDTH-1:0] rd0,
  output logic [WIDTH-1:0] rd1
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= (wdata & wmask)
                  | (mem[waddr] & ~wmask);
    end
  end

  assign rd0 = mem[ra0];
  assign rd1 = mem[ra1];

endmodule

// File: rtl/ram_dp_lut_clr.sv
// Dual-port LUT RAM with masked writes, optional output registers
// and a clear sequencer that sweeps CLR_VAL into every word.
module ram_dp_lut_clr
  import ram_lut_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               DEPTH    = 64,
  parameter logic [WIDTH-1:0] CLR_VAL  = {WIDTH{1'b0}},
  parameter bit               READ_REG = 1'b0
) (
  input logic             WCLK,
  input logic             RST_N,
  ram_dp_lut_clr_if.slave bus
);

  localparam int AW = ram_clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  ram_clr_state_t   state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             busy, a_ok, dp_ok;
  logic             user_we, mem_we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata, wmask;
  logic [WIDTH-1:0] rd0, rd1;

  assign busy  = (state_q == ST_CLEAR);
  assign a_ok  = {1'b0, bus.A} < DEPTH_W;
  assign dp_ok = {1'b0, bus.DPRA} < DEPTH_W;

  // A clear request in the same cycle drops the user write.
  assign user_we = !busy && bus.WE
                && !bus.CLR && a_ok;
  assign mem_we  = RST_N && (busy || user_we);
  assign waddr   = busy ? cnt_q : bus.A;
  assign wdata   = busy ? CLR_VAL : bus.D;
  assign wmask   = busy ? {WIDTH{1'b1}}
                        : bus.WMASK;

  always_ff @(posedge WCLK) begin
    if (!RST_N) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        if (cnt_q == LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      ST_IDLE: begin
        if (bus.CLR) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  ram_lut_core #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_core (
    .clk   (WCLK),
    .we    (mem_we),
    .waddr (waddr),
    .wdata (wdata),
    .wmask (wmask),
    .ra0   (bus.A),
    .ra1   (bus.DPRA),
    .rd0   (rd0),
    .rd1   (rd1)
  );

  generate
    if (READ_REG) begin : g_reg
      logic [WIDTH-1:0] spo_q, dpo_q;
      logic [WIDTH-1:0] spo_n, dpo_n;
      logic [WIDTH-1:0] merged;
      logic             hit0, hit1;

      // Write-first: a port hitting the committing word sees the merge.
      assign merged = (wdata & wmask) | (rd0 & ~wmask);
      assign hit0   = mem_we && (waddr == bus.A);
      assign hit1   = mem_we && (waddr == bus.DPRA);
      assign spo_n  = !a_ok  ? '0 : hit0 ? merged : rd0;
      assign dpo_n  = !dp_ok ? '0
                    : hit1 ? ((wdata & wmask) | (rd1 & ~wmask))
                    : rd1;

      always_ff @(posedge WCLK) begin
        if (!RST_N) begin
          spo_q <= '0;
          dpo_q <= '0;
        end else begin
          spo_q <= spo_n;
          dpo_q <= dpo_n;
        end
      end

      assign bus.SPO = spo_q;
      assign bus.DPO = dpo_q;
    end else begin : g_comb
      assign bus.SPO = a_ok  ? rd0 : '0;
      assign bus.DPO = dp_ok ? rd1 : '0;
    end
  endgenerate

  assign bus.BUSY     = busy;
  assign bus.CLR_DONE = done_q;

endmodule

// File: tb/tb_ram_dp_lut_clr.sv
// Bench for ram_dp_lut_clr: async 64-deep, registered 64-deep and
// async 48-deep instances driven in lockstep against a word model.
module tb_ram_dp_lut_clr;
  import ram_lut_pkg::*;

  localparam int AW0 = ram_clog2(64);
  localparam int AW2 = ram_clog2(48);

  logic WCLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 WCLK = ~WCLK;

  ram_dp_lut_clr_if #(.WIDTH(8), .AW(AW0)) b0();
  ram_dp_lut_clr_if #(.WIDTH(8), .AW(AW0)) b1();
  ram_dp_lut_clr_if #(.WIDTH(8), .AW(AW2)) b2();

  ram_dp_lut_clr #(.WIDTH(8), .DEPTH(64), .CLR_VAL(8'hA5),
    .READ_REG(1'b0)) u0 (.WCLK(WCLK), .RST_N(RST_N), .bus(b0));
  ram_dp_lut_clr #(.WIDTH(8), .DEPTH(64), .CLR_VAL(8'hA5),
    .READ_REG(1'b1)) u1 (.WCLK(WCLK), .RST_N(RST_N), .bus(b1));
  ram_dp_lut_clr #(.WIDTH(8), .DEPTH(48), .CLR_VAL(8'hA5),
    .READ_REG(1'b0)) u2 (.WCLK(WCLK), .RST_N(RST_N), .bus(b2));

  int nvec = 0;
  int nerr = 0;
  logic [7:0] m0 [64];
  logic [7:0] m2 [48];
  logic [7:0] sb_q [$];
  int n_busy [3];
  int n_done [3];
  int t_done [3];

  task automatic tick;
    @(posedge WCLK);
    #1;
  endtask

  task automatic set_in(input logic we, input logic [5:0] a,
                        input logic [7:0] d, input logic [7:0] m,
                        input logic [5:0] dp, input logic clr);
    b0.WE = we; b0.A = a; b0.D = d; b0.WMASK = m;
    b0.DPRA = dp; b0.CLR = clr;
    b1.WE = we; b1.A = a; b1.D = d; b1.WMASK = m;
    b1.DPRA = dp; b1.CLR = clr;
    b2.WE = we; b2.A = a; b2.D = d; b2.WMASK = m;
    b2.DPRA = dp; b2.CLR = clr;
  endtask

  task automatic model_write(input int a, input logic [7:0] d,
                             input logic [7:0] m);
    m0[a] = (d & m) | (m0[a] & ~m);
    if (a < 48) m2[a] = (d & m) | (m2[a] & ~m);
  endtask

  task automatic model_clear;
    for (int i = 0; i < 64; i++) m0[i] = 8'hA5;
    for (int i = 0; i < 48; i++) m2[i] = 8'hA5;
  endtask

  // Ticks until each instance leaves CLEAR, bounded at 80 cycles.
  task automatic measure;
    logic bz [3];
    logic dn [3];
    for (int k = 0; k < 3; k++) begin
      n_busy[k] = 0; n_done[k] = 0; t_done[k] = -1;
    end
    for (int i = 1; i <= 80; i++) begin
      tick;
      bz[0] = b0.BUSY; bz[1] = b1.BUSY; bz[2] = b2.BUSY;
      dn[0] = b0.CLR_DONE; dn[1] = b1.CLR_DONE;
      dn[2] = b2.CLR_DONE;
      for (int k = 0; k < 3; k++) begin
        if (bz[k] !== 1'b1 && n_busy[k] == 0) n_busy[k] = i;
        if (dn[k] === 1'b1) begin
          n_done[k]++;
          t_done[k] = i;
        end
      end
    end
  endtask

  task automatic test_reset;
    set_in(1'b0, 6'd0, 8'h00, 8'h00, 6'd0, 1'b0);
    RST_N = 1'b0;
    tick; tick;
    nvec++;
    if ({b0.BUSY, b1.BUSY, b2.BUSY} !== 3'b111) begin
      nerr++;
      $display("FAIL rst_busy: got %b want 111",
               {b0.BUSY, b1.BUSY, b2.BUSY});
    end
    nvec++;
    if ({b0.CLR_DONE, b1.CLR_DONE, b2.CLR_DONE} !== 3'b000) begin
      nerr++;
      $display("FAIL rst_done: got %b want 000",
               {b0.CLR_DONE, b1.CLR_DONE, b2.CLR_DONE});
    end
    nvec++;
    if (b1.SPO !== 8'h00 || b1.DPO !== 8'h00) begin
      nerr++;
      $display("FAIL rst_rdreg: got %h/%h want 00/00",
               b1.SPO, b1.DPO);
    end
    RST_N = 1'b1;
    measure;
    for (int k = 0; k < 3; k++) begin
      nvec++;
      if (n_busy[k] != ((k == 2) ? 48 : 64) || n_done[k] != 1
          || t_done[k] != n_busy[k]) begin
        nerr++;
        $display("FAIL init_sweep%0d: busy %0d done %0d at %0d want %0d/1",
                 k, n_busy[k], n_done[k], t_done[k],
                 (k == 2) ? 48 : 64);
      end
    end
    model_clear;
  endtask

  task automatic test_sweep_read;
    logic [7:0] e2, exp;
    for (int i = 0; i < 64; i++) begin
      set_in(1'b0, 6'(i), 8'h00, 8'h00, 6'(i), 1'b0);
      #1;
      e2 = (i < 48) ? m2[i] : 8'h00;
      nvec++;
      if (b0.DPO !== m0[i] || b0.SPO !== m0[i]) begin
        nerr++;
        $display("FAIL rd64[%0d]: got %h/%h want %h",
                 i, b0.SPO, b0.DPO, m0[i]);
      end
      nvec++;
      if (b2.DPO !== e2 || b2.SPO !== e2) begin
        nerr++;
        $display("FAIL rd48[%0d]: got %h/%h want %h",
                 i, b2.SPO, b2.DPO, e2);
      end
      sb_q.push_back(m0[i]);
      tick;
      exp = sb_q.pop_front();
      nvec++;
      if (b1.DPO !== exp || b1.SPO !== exp) begin
        nerr++;
        $display("FAIL rdreg[%0d]: got %h/%h want %h",
                 i, b1.SPO, b1.DPO, exp);
      end
    end
  endtask

  task automatic test_masked_write;
    set_in(1'b1, 6'd5, 8'h3C, 8'h0F, 6'd5, 1'b0);
    model_write(5, 8'h3C, 8'h0F);
    tick;
    set_in(1'b0, 6'd5, 8'h00, 8'h00, 6'd5, 1'b0);
    #1;
    nvec++;
    if (b0.DPO !== 8'hAC || b0.SPO !== m0[5]) begin
      nerr++;
      $display("FAIL mask_wr: got %h/%h want AC/%h",
               b0.DPO, b0.SPO, m0[5]);
    end
    tick;
    nvec++;
    if (b1.DPO !== 8'hAC || b1.SPO !== 8'hAC) begin
      nerr++;
      $display("FAIL mask_wr_reg: got %h/%h want AC/AC",
               b1.DPO, b1.SPO);
    end
  endtask

  task automatic test_write_first;
    logic [7:0] exp;
    set_in(1'b1, 6'd7, 8'h11, 8'hFF, 6'd7, 1'b0);
    model_write(7, 8'h11, 8'hFF);
    sb_q.push_back(m0[7]);
    tick;
    set_in(1'b0, 6'd7, 8'h00, 8'h00, 6'd7, 1'b0);
    exp = sb_q.pop_front();
    nvec++;
    if (b1.DPO !== exp || b1.SPO !== exp) begin
      nerr++;
      $display("FAIL wr_first: got %h/%h want %h",
               b1.DPO, b1.SPO, exp);
    end
    nvec++;
    if (b0.DPO !== 8'h11) begin
      nerr++;
      $display("FAIL wr_async7: got %h want 11", b0.DPO);
    end
  endtask

  task automatic test_out_of_range;
    set_in(1'b1, 6'd50, 8'hFF, 8'hFF, 6'd50, 1'b0);
    model_write(50, 8'hFF, 8'hFF);
    tick;
    set_in(1'b0, 6'd50, 8'h00, 8'h00, 6'd50, 1'b0);
    #1;
    nvec++;
    if (b2.DPO !== 8'h00 || b2.SPO !== 8'h00) begin
      nerr++;
      $display("FAIL oor_rd: got %h/%h want 00/00",
               b2.DPO, b2.SPO);
    end
    nvec++;
    if (b0.DPO !== m0[50]) begin
      nerr++;
      $display("FAIL inr_wr50: got %h want %h", b0.DPO, m0[50]);
    end
    for (int i = 0; i < 48; i++) begin
      b2.DPRA = 6'(i);
      #1;
      nvec++;
      if (b2.DPO !== m2[i]) begin
        nerr++;
        $display("FAIL oor_keep[%0d]: got %h want %h",
                 i, b2.DPO, m2[i]);
      end
    end
    b2.DPRA = 6'd0;
    tick;
  endtask

  task automatic test_back_to_back;
    logic [7:0] d, m, exp;
    int a;
    for (int i = 0; i < 8; i++) begin
      a = 16 + i;
      d = 8'($urandom);
      m = 8'($urandom);
      set_in(1'b1, 6'(a), d, m, 6'(a), 1'b0);
      model_write(a, d, m);
      sb_q.push_back(m0[a]);
      tick;
      exp = sb_q.pop_front();
      nvec++;
      if (b1.DPO !== exp) begin
        nerr++;
        $display("FAIL b2b_reg[%0d]: got %h want %h", a, b1.DPO, exp);
      end
      nvec++;
      if (b0.DPO !== m0[a] || b2.DPO !== m2[a]) begin
        nerr++;
        $display("FAIL b2b_async[%0d]: got %h/%h want %h/%h",
                 a, b0.DPO, b2.DPO, m0[a], m2[a]);
      end
    end
    set_in(1'b0, 6'd0, 8'h00, 8'h00, 6'd0, 1'b0);
    tick;
  endtask

  task automatic test_clr_we;
    set_in(1'b1, 6'd9, 8'h00, 8'hFF, 6'd9, 1'b1);
    tick;
    set_in(1'b0, 6'd9, 8'h00, 8'h00, 6'd9, 1'b0);
    #1;
    nvec++;
    if (b0.BUSY !== 1'b1 || b0.DPO !== m0[9]) begin
      nerr++;
      $display("FAIL clr_we: busy %b dpo %h want 1/%h",
               b0.BUSY, b0.DPO, m0[9]);
    end
    b0.DPRA = 6'd5;
    #1;
    nvec++;
    if (b0.DPO !== m0[5]) begin
      nerr++;
      $display("FAIL clr_partial: got %h want %h", b0.DPO, m0[5]);
    end
    repeat (20) tick;
    RST_N = 1'b0;
    tick;
    RST_N = 1'b1;
    measure;
    for (int k = 0; k < 3; k++) begin
      nvec++;
      if (n_busy[k] != ((k == 2) ? 48 : 64) || n_done[k] != 1) begin
        nerr++;
        $display("FAIL rst_restart%0d: busy %0d done %0d want %0d/1",
                 k, n_busy[k], n_done[k], (k == 2) ? 48 : 64);
      end
    end
    model_clear;
  endtask

  task automatic test_clr_busy;
    set_in(1'b0, 6'd0, 8'h00, 8'h00, 6'd0, 1'b1);
    tick;
    b0.CLR = 1'b0; b1.CLR = 1'b0; b2.CLR = 1'b0;
    repeat (8) tick;
    b0.CLR = 1'b1; b1.CLR = 1'b1; b2.CLR = 1'b1;
    tick;
    b0.CLR = 1'b0; b1.CLR = 1'b0; b2.CLR = 1'b0;
    measure;
    for (int k = 0; k < 3; k++) begin
      nvec++;
      if (n_busy[k] != ((k == 2) ? 39 : 55) || n_done[k] != 1) begin
        nerr++;
        $display("FAIL clr_busy%0d: busy %0d done %0d want %0d/1",
                 k, n_busy[k], n_done[k], (k == 2) ? 39 : 55);
      end
    end
  endtask

  initial begin
    test_reset;
    test_sweep_read;
    test_masked_write;
    test_write_first;
    test_out_of_range;
    test_back_to_back;
    test_clr_we;
    test_sweep_read;
    test_clr_busy;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
